// File: rtl/spram_req_ctrl.sv
// spram_req_ctrl: valid/ready request front-end for spram with init sweep and 3-entry response buffer
module spram_req_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 256,
  parameter bit INIT_EN = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int AW = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [AW-1:0]         req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  init_done,
  output logic                  ram_en,
  output logic                  ram_wr_en,
  output logic [AW-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);
  typedef enum logic {INIT, RUN} state_t;
  localparam logic [AW-1:0] LAST = AW'(DATA_DEPTH - 1);
  state_t state;
  logic [AW-1:0] cnt;
  logic inflight, accept, pop, init;
  logic [1:0] occ, rd_ptr, wr_ptr;
  logic [DATA_WIDTH-1:0] fifo [3];
  always_comb begin
    init = !rst && state == INIT;
    req_ready = !rst && state == RUN && ({1'b0, occ} + {2'b0, inflight} < 3'd3);
    accept = req_valid && req_ready;
    init_done = !rst && state == RUN;
    rsp_valid = !rst && occ != 2'd0;
    rsp_data = rsp_valid ? fifo[rd_ptr] : '0;
    pop = rsp_valid && rsp_ready;
    ram_en = init || accept;
    ram_wr_en = init || (accept && req_wr);
    ram_addr = init ? cnt : accept ? req_addr : '0;
    ram_wr_data = init ? INIT_VALUE : accept ? req_wdata : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT_EN ? INIT : RUN;
      cnt <= '0;
      inflight <= 1'b0;
      occ <= 2'd0;
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
    end else begin
      if (state == INIT) begin
        cnt <= cnt == LAST ? cnt : cnt + 1'b1;
        state <= cnt == LAST ? RUN : INIT;
      end
      inflight <= accept && !req_wr;
      if (inflight) wr_ptr <= wr_ptr == 2'd2 ? 2'd0 : wr_ptr + 2'd1;
      if (pop) rd_ptr <= rd_ptr == 2'd2 ? 2'd0 : rd_ptr + 2'd1;
      occ <= occ + 2'(inflight) - 2'(pop);
    end
  end
  // rd_data is only stable the cycle after the read edge, so capture it unconditionally there
  always_ff @(posedge clk) begin
    if (inflight) fifo[wr_ptr] <= ram_rd_data;
  end
endmodule

// File: tb/tb_spram_req_ctrl.sv
// tb_spram_req_ctrl: randomized scoreboard bench for spram_req_ctrl with a behavioural spram and memory model
module tb_spram_req_ctrl;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_wr = 0;
  logic [7:0] req_addr = 0, req_wdata = 0;
  logic rsp_valid, rsp_ready = 1, init_done;
  logic [7:0] rsp_data;
  logic ram_en, ram_wr_en;
  logic [7:0] ram_addr, ram_wr_data, ram_rd_data;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] exp_q [$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, pop_cnt = 0, first_pop = 0, last_pop = 0, stall_cnt = 0;
  bit rand_rr = 0;

  spram_req_ctrl #(.DATA_WIDTH(8), .DATA_DEPTH(256), .INIT_EN(1'b1), .INIT_VALUE(8'h00)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .init_done(init_done), .ram_en(ram_en), .ram_wr_en(ram_wr_en),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural spram: read data held until the next enabled read
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
      else ram_rd_data <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor/scoreboard: responses popped and compared; accepted requests update the model
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid && rsp_ready) begin
        check("rsp_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("rsp_data", rsp_data, exp_q.pop_front());
          pop_cnt++;
          if (pop_cnt == 1) first_pop = cyc;
          last_pop = cyc;
        end
      end
      if (req_valid && req_ready) begin
        if (req_wr) ref_mem[req_addr] = req_wdata;
        else exp_q.push_back(ref_mem[req_addr]);
      end
      if (init_done) check("outstanding_le_3", exp_q.size() <= 3, 1);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rr) rsp_ready = 1'($urandom_range(0, 1));
  end

  task automatic do_reset();
    int wr_cycles, done_at;
    rst = 1;
    req_valid = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("rst_outputs", {req_ready, rsp_valid, init_done, ram_en, ram_wr_en, |ram_addr, |ram_wr_data, |rsp_data}, 0);
    rst = 0;
    for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;
    wr_cycles = 0;
    done_at = -1;
    for (int i = 0; i < 400 && done_at < 0; i++) begin
      @(negedge clk);
      if (init_done) done_at = i;
      else if (ram_en && ram_wr_en && ram_addr == i[7:0] && ram_wr_data == 8'h00 && !req_ready && !rsp_valid)
        wr_cycles++;
    end
    check("init_writes", wr_cycles, 256);
    check("init_done_cycle", done_at, 256);
    check("req_ready_at_done", req_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic wr, input logic [7:0] addr, input logic [7:0] data);
    int n;
    req_valid = 1;
    req_wr = wr;
    req_addr = addr;
    req_wdata = data;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      stall_cnt++;
      n++;
      if (n > 200) begin
        check("req_accept_timeout", 1'b0, 1'b1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    req_valid = 0;
    rsp_ready = 1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int p0;
    do_reset();
    send(0, 8'h05, 0);
    send(0, 8'hff, 0);
    drain();
    // write then read same address: new data, 2-cycle latency
    send(1, 8'h03, 8'hef);
    send(0, 8'h03, 0);
    req_valid = 0;
    @(negedge clk);
    check("lat_cycle1_quiet", rsp_valid, 0);
    @(negedge clk);
    check("lat_cycle2_valid", rsp_valid, 1);
    check("lat_data", rsp_data, 8'hef);
    drain();
    // read followed by write to same address returns old data
    send(0, 8'h03, 0);
    send(1, 8'h03, 8'h11);
    send(0, 8'h03, 0);
    drain();
    // back-pressure
    send(1, 8'h00, 8'hde);
    send(1, 8'h01, 8'had);
    send(1, 8'h02, 8'hbe);
    send(1, 8'h03, 8'hef);
    rsp_ready = 0;
    p0 = pop_cnt;
    send(0, 8'h00, 0);
    send(0, 8'h01, 0);
    send(0, 8'h02, 0);
    req_valid = 1;
    req_wr = 0;
    req_addr = 8'h03;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_hold", req_ready, 0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1;
    send(0, 8'h03, 0);
    drain();
    check("bp_count", pop_cnt - p0, 4);
    // streaming
    for (int a = 0; a < 256; a++) send(1, a[7:0], a[0] ? 8'ha5 : 8'h5a);
    drain();
    pop_cnt = 0;
    stall_cnt = 0;
    for (int a = 0; a < 256; a++) send(0, a[7:0], 0);
    drain();
    check("stream_stalls", stall_cnt, 0);
    check("stream_count", pop_cnt, 256);
    check("stream_span", last_pop - first_pop, 255);
    // random mix
    rand_rr = 1;
    for (int i = 0; i < 1000; i++) begin
      send(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    rand_rr = 0;
    drain();
    // reset with 2 buffered and 1 in flight
    rsp_ready = 0;
    send(0, 8'h10, 0);
    send(0, 8'h11, 0);
    send(0, 8'h12, 0);
    do_reset();
    rsp_ready = 1;
    p0 = pop_cnt;
    idle(10);
    check("no_stale_rsp", pop_cnt - p0, 0);
    send(0, 8'h00, 0);
    send(0, 8'h12, 0);
    drain();
    check("post_reset_count", pop_cnt - p0, 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish before timeout");
    $fatal(1, "timeout");
  end
endmodule
